// File: rtl/rsa_exp_scheduler_if.sv
// Bundle between the RSA exponent scheduler, its encrypt/decrypt requesters,
// the key-setup logic and the shared mod_exponent engine.
interface rsa_exp_scheduler_if #(
   parameter int WIDTH = 64
);
   logic             keys_valid_in;
   logic [WIDTH-1:0] e_in;
   logic [WIDTH-1:0] d_in;
   logic             enc_valid_in;
   logic [WIDTH-1:0] enc_msg_in;
   logic             enc_ready_out;
   logic             dec_valid_in;
   logic [WIDTH-1:0] dec_msg_in;
   logic             dec_ready_out;
   logic [WIDTH-1:0] exp_base_out;
   logic [WIDTH-1:0] exp_exponent_out;
   logic             exp_valid_out;
   logic [WIDTH-1:0] exp_result_in;
   logic             exp_valid_in;
   logic [WIDTH-1:0] result_out;
   logic             result_valid_out;
   logic             result_is_dec_out;
   logic             error_out;
   logic             busy_out;

   modport slave (
      input  keys_valid_in, e_in, d_in,
      input  enc_valid_in, enc_msg_in, dec_valid_in, dec_msg_in,
      input  exp_result_in, exp_valid_in,
      output enc_ready_out, dec_ready_out,
      output exp_base_out, exp_exponent_out, exp_valid_out,
      output result_out, result_valid_out, result_is_dec_out,
      output error_out, busy_out
   );

   modport master (
      output keys_valid_in, e_in, d_in,
      output enc_valid_in, enc_msg_in, dec_valid_in, dec_msg_in,
      output exp_result_in, exp_valid_in,
      input  enc_ready_out, dec_ready_out,
      input  exp_base_out, exp_exponent_out, exp_valid_out,
      input  result_out, result_valid_out, result_is_dec_out,
      input  error_out, busy_out
   );
endinterface

// File: rtl/rsa_exp_scheduler.sv
// Round-robin scheduler sharing one mod_exponent between encrypt (exponent e)
// and decrypt (exponent d) requesters; returns each result tagged with its job type.
module rsa_exp_scheduler #(
   parameter int WIDTH   = 64,
   parameter int TIMEOUT = 65536
) (
   input  logic               clk_in,
   input  logic               rst_in,
   rsa_exp_scheduler_if.slave bus
);
   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             last_grant_dec_q;
   logic [WIDTH-1:0] base_q;
   logic [WIDTH-1:0] expo_q;
   logic [WIDTH-1:0] result_q;
   logic             is_dec_q;
   logic [CNT_W-1:0] cnt_q;

   logic grant_enc;
   logic grant_dec;
   logic accept;
   logic keys_lost;
   logic timeout_hit;

   // Ready is held low while reset is asserted so every output reads 0 in reset.
   always_comb begin
      grant_enc = 1'b0;
      grant_dec = 1'b0;
      if (state_q == S_IDLE && bus.keys_valid_in && !rst_in) begin
         if (bus.enc_valid_in && bus.dec_valid_in) begin
            grant_enc = last_grant_dec_q;
            grant_dec = ~last_grant_dec_q;
         end else begin
            grant_enc = bus.enc_valid_in;
            grant_dec = bus.dec_valid_in;
         end
      end
   end

   assign accept      = grant_enc | grant_dec;
   assign keys_lost   = ~bus.keys_valid_in;
   assign timeout_hit = (cnt_q == CNT_LAST);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Keys loss beats a returning result, which in turn beats the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_LAUNCH;
         S_LAUNCH: state_d = keys_lost ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (keys_lost)             state_d = S_IDLE;
            else if (bus.exp_valid_in) state_d = S_DONE;
            else if (timeout_hit)      state_d = S_IDLE;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.enc_ready_out    = grant_enc;
      bus.dec_ready_out    = grant_dec;
      bus.exp_valid_out    = (state_q == S_LAUNCH);
      bus.result_valid_out = (state_q == S_DONE);
      bus.busy_out         = (state_q != S_IDLE);
      bus.error_out        = 1'b0;
      if (state_q == S_LAUNCH && keys_lost) begin
         bus.error_out = 1'b1;
      end else if (state_q == S_WAIT) begin
         bus.error_out = keys_lost | (~bus.exp_valid_in & timeout_hit);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         last_grant_dec_q <= 1'b1;
         base_q           <= '0;
         expo_q           <= '0;
         is_dec_q         <= 1'b0;
         result_q         <= '0;
         cnt_q            <= '0;
      end else begin
         if (accept) begin
            base_q           <= grant_dec ? bus.dec_msg_in : bus.enc_msg_in;
            expo_q           <= grant_dec ? bus.d_in : bus.e_in;
            is_dec_q         <= grant_dec;
            last_grant_dec_q <= grant_dec;
         end
         if (state_q == S_LAUNCH) begin
            cnt_q <= '0;
         end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (state_q == S_WAIT && !keys_lost && bus.exp_valid_in) begin
            result_q <= bus.exp_result_in;
         end
      end
   end

   assign bus.exp_base_out      = base_q;
   assign bus.exp_exponent_out  = expo_q;
   assign bus.result_out        = result_q;
   assign bus.result_is_dec_out = is_dec_q;
endmodule

// File: tb/tb_rsa_exp_scheduler.sv
// Directed bench for rsa_exp_scheduler with a behavioural mod_exponent responder
// (N = 211*149, e = 65537, d = 24113) and a short TIMEOUT of 16.
module tb_rsa_exp_scheduler;
   localparam longint unsigned MOD_N = 64'd31439;
   localparam logic [63:0]     E_KEY = 64'd65537;
   localparam logic [63:0]     D_KEY = 64'd24113;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rsa_exp_scheduler_if #(.WIDTH(64)) ifc ();

   rsa_exp_scheduler #(.WIDTH(64), .TIMEOUT(16)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (ifc)
   );

   int n_checks = 0;
   int n_errors = 0;
   int resp_lat = 0;
   int late_req = 0;
   int n_launch = 0;
   int n_res    = 0;
   int n_errp   = 0;

   typedef struct {
      logic keys;
      logic enc_v;
      logic dec_v;
      logic exp_enc_rdy;
      logic exp_dec_rdy;
   } arb_vec_t;

   arb_vec_t tbl [6];

   function automatic longint unsigned modexp(input longint unsigned b,
                                              input longint unsigned x,
                                              input longint unsigned n);
      longint unsigned r, bb, xx;
      r  = 1 % n;
      bb = b % n;
      xx = x;
      while (xx != 0) begin
         if (xx[0]) r = (r * bb) % n;
         bb = (bb * bb) % n;
         xx = xx >> 1;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Behavioural engine: answers resp_lat cycles after the launch pulse (0 = never).
   initial begin : responder
      int cd;
      int late_seen;
      longint unsigned rb, rx;
      cd = 0; late_seen = 0; rb = 0; rx = 0;
      ifc.exp_valid_in  = 1'b0;
      ifc.exp_result_in = '0;
      forever begin
         @(posedge clk); #1;
         ifc.exp_valid_in = 1'b0;
         if (rst) begin
            cd = 0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  ifc.exp_result_in = modexp(rb, rx, MOD_N);
                  ifc.exp_valid_in  = 1'b1;
               end
            end
            if (ifc.exp_valid_out && resp_lat > 0) begin
               rb = ifc.exp_base_out;
               rx = ifc.exp_exponent_out;
               cd = resp_lat;
            end
            if (late_req != late_seen) begin
               late_seen         = late_req;
               ifc.exp_result_in = 64'hDEAD_BEEF;
               ifc.exp_valid_in  = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (ifc.exp_valid_out)    n_launch++;
      if (ifc.result_valid_out) n_res++;
      if (ifc.error_out)        n_errp++;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   // Offers one job until granted; returns #1 into the LAUNCH cycle.
   task automatic offer(input bit dec, input logic [63:0] msg);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (dec) begin ifc.dec_valid_in = 1'b1; ifc.dec_msg_in = msg; end
         else     begin ifc.enc_valid_in = 1'b1; ifc.enc_msg_in = msg; end
         #1;
         got = dec ? ifc.dec_ready_out : ifc.enc_ready_out;
      end
      chk1("offer_ready", got, 1'b1);
      @(negedge clk);
      ifc.enc_valid_in = 1'b0;
      ifc.dec_valid_in = 1'b0;
      #1;
      chk1("launch_pulse", ifc.exp_valid_out, 1'b1);
   endtask

   task automatic wait_result(output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 60 && !seen; i++) begin
         @(negedge clk); #1;
         if (ifc.result_valid_out) begin seen = 1'b1; n = i; end
      end
      chk1("result_arrived", seen, 1'b1);
   endtask

   initial begin : main
      int lat, rdy_seen, base_cnt, err_cnt, err_at;
      bit g_dec [8];
      int g_cyc [8];
      bit r_tag [8];
      logic [63:0] r_val [8];
      int ng, nr;
      logic [63:0] ct;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      ifc.keys_valid_in = 1'b0;
      ifc.e_in          = E_KEY;
      ifc.d_in          = D_KEY;
      ifc.enc_valid_in  = 1'b1;
      ifc.enc_msg_in    = 64'h55;
      ifc.dec_valid_in  = 1'b0;
      ifc.dec_msg_in    = '0;

      // Reset values, then no scheduling without keys
      @(negedge clk); #1;
      chk1("rst_enc_ready", ifc.enc_ready_out, 1'b0);
      chk1("rst_dec_ready", ifc.dec_ready_out, 1'b0);
      chk1("rst_exp_valid", ifc.exp_valid_out, 1'b0);
      chk1("rst_res_valid", ifc.result_valid_out, 1'b0);
      chk1("rst_error", ifc.error_out, 1'b0);
      chk1("rst_busy", ifc.busy_out, 1'b0);
      chk("rst_base", ifc.exp_base_out, 64'h0);
      chk("rst_expo", ifc.exp_exponent_out, 64'h0);
      chk("rst_result", ifc.result_out, 64'h0);
      @(negedge clk); rst = 1'b0;
      base_cnt = n_launch;
      rdy_seen = 0;
      repeat (10) begin
         @(negedge clk); #1;
         if (ifc.enc_ready_out) rdy_seen++;
      end
      chk("nokeys_ready_cycles", 64'(rdy_seen), 64'd0);
      chk("nokeys_launches", 64'(n_launch - base_cnt), 64'd0);
      ifc.enc_valid_in = 1'b0;

      // Arbitration table (valids withdrawn before the edge, so nothing is accepted)
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ifc.keys_valid_in = tbl[i].keys;
         ifc.enc_valid_in  = tbl[i].enc_v;
         ifc.dec_valid_in  = tbl[i].dec_v;
         #1;
         chk1($sformatf("arb%0d_enc_ready", i), ifc.enc_ready_out, tbl[i].exp_enc_rdy);
         chk1($sformatf("arb%0d_dec_ready", i), ifc.dec_ready_out, tbl[i].exp_dec_rdy);
         ifc.enc_valid_in = 1'b0;
         ifc.dec_valid_in = 1'b0;
      end
      ifc.keys_valid_in = 1'b1;

      // Single encrypt job: launch contents, latency and result
      resp_lat = 3;
      offer(1'b0, 64'h1234);
      chk("enc_base", ifc.exp_base_out, 64'h1234);
      chk("enc_expo", ifc.exp_exponent_out, 64'd65537);
      chk1("enc_busy", ifc.busy_out, 1'b1);
      wait_result(lat);
      chk("enc_latency", 64'(lat), 64'd4);
      chk("enc_result", ifc.result_out, 64'(modexp(64'h1234, 64'd65537, MOD_N)));
      chk1("enc_tag", ifc.result_is_dec_out, 1'b0);
      chk("enc_base_held", ifc.exp_base_out, 64'h1234);
      @(negedge clk); #1;
      chk1("enc_idle", ifc.busy_out, 1'b0);
      chk("enc_result_held", ifc.result_out, 64'(modexp(64'h1234, 64'd65537, MOD_N)));

      // Round-robin with both requesters always valid, engine returns 5 cycles after accept
      do_reset();
      resp_lat = 4;
      ifc.enc_msg_in = 64'h11;
      ifc.dec_msg_in = 64'h22;
      ng = 0; nr = 0;
      for (int i = 0; i < 8; i++) begin
         g_dec[i] = 1'b0; g_cyc[i] = 0; r_tag[i] = 1'b0; r_val[i] = '0;
      end
      for (int c = 0; c < 200 && nr < 4; c++) begin
         @(negedge clk);
         ifc.enc_valid_in = 1'b1;
         ifc.dec_valid_in = 1'b1;
         #1;
         if (ng < 8 && (ifc.enc_ready_out || ifc.dec_ready_out)) begin
            g_dec[ng] = ifc.dec_ready_out;
            g_cyc[ng] = c;
            ng++;
         end
         if (ifc.result_valid_out) begin
            r_tag[nr] = ifc.result_is_dec_out;
            r_val[nr] = ifc.result_out;
            nr++;
         end
      end
      @(negedge clk);
      ifc.enc_valid_in = 1'b0;
      ifc.dec_valid_in = 1'b0;
      chk("rr_grant_count", 64'(ng), 64'd4);
      chk("rr_result_count", 64'(nr), 64'd4);
      if (ng >= 4 && nr >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk1($sformatf("rr_grant%0d", i), g_dec[i], (i % 2) == 1);
            chk1($sformatf("rr_tag%0d", i), r_tag[i], (i % 2) == 1);
            chk($sformatf("rr_result%0d", i), r_val[i],
                (i % 2) == 1 ? 64'(modexp(64'h22, D_KEY, MOD_N)) : 64'(modexp(64'h11, E_KEY, MOD_N)));
         end
         chk("rr_spacing", 64'(g_cyc[1] - g_cyc[0]), 64'd7);
      end

      // Encrypt then decrypt loopback; the message must be below N to round-trip
      do_reset();
      resp_lat = 2;
      offer(1'b0, 64'h7ABC);
      wait_result(lat);
      ct = ifc.result_out;
      chk("loop_cipher", ct, 64'(modexp(64'h7ABC, E_KEY, MOD_N)));
      offer(1'b1, ct);
      chk("loop_dec_expo", ifc.exp_exponent_out, 64'd24113);
      wait_result(lat);
      chk("loop_plain", ifc.result_out, 64'h7ABC);
      chk1("loop_tag", ifc.result_is_dec_out, 1'b1);

      // Timeout: engine never answers
      do_reset();
      resp_lat = 0;
      offer(1'b0, 64'h99);
      base_cnt = n_res;
      err_cnt  = n_errp;
      err_at   = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk); #1;
         if (ifc.error_out && err_at == 0) err_at = i;
      end
      chk("to_err_cycle", 64'(err_at), 64'd16);
      chk("to_err_pulses", 64'(n_errp - err_cnt), 64'd1);
      chk("to_no_result", 64'(n_res - base_cnt), 64'd0);
      chk1("to_idle", ifc.busy_out, 1'b0);

      // Result on the last allowed cycle wins over the timeout
      resp_lat = 16;
      err_cnt  = n_errp;
      offer(1'b0, 64'h5);
      wait_result(lat);
      chk("to_edge_latency", 64'(lat), 64'd17);
      chk("to_edge_no_error", 64'(n_errp - err_cnt), 64'd0);
      chk("to_edge_result", ifc.result_out, 64'(modexp(64'h5, E_KEY, MOD_N)));

      // Keys dropped in WAIT, then a late result is ignored
      do_reset();
      resp_lat = 0;
      offer(1'b0, 64'h77);
      repeat (3) @(negedge clk);
      @(negedge clk);
      ifc.keys_valid_in = 1'b0;
      #1;
      chk1("kl_error", ifc.error_out, 1'b1);
      @(negedge clk); #1;
      chk1("kl_idle", ifc.busy_out, 1'b0);
      chk1("kl_error_pulse", ifc.error_out, 1'b0);
      base_cnt = n_res;
      late_req++;
      repeat (4) @(negedge clk);
      #1;
      chk("kl_late_ignored", 64'(n_res - base_cnt), 64'd0);
      chk1("kl_still_idle", ifc.busy_out, 1'b0);

      // Keys loss in the same cycle as the result: abort wins
      ifc.keys_valid_in = 1'b1;
      resp_lat = 3;
      offer(1'b1, 64'h44);
      repeat (2) @(negedge clk);
      @(negedge clk);
      ifc.keys_valid_in = 1'b0;
      #1;
      chk1("kr_error", ifc.error_out, 1'b1);
      base_cnt = n_res;
      repeat (4) @(negedge clk);
      #1;
      chk("kr_no_result", 64'(n_res - base_cnt), 64'd0);
      chk1("kr_idle", ifc.busy_out, 1'b0);

      // Asynchronous reset while waiting
      ifc.keys_valid_in = 1'b1;
      resp_lat = 0;
      offer(1'b1, 64'h3C);
      repeat (2) @(negedge clk);
      @(negedge clk);
      ifc.enc_valid_in = 1'b1;
      rst = 1'b1;
      #1;
      chk1("ar_busy", ifc.busy_out, 1'b0);
      chk1("ar_enc_ready", ifc.enc_ready_out, 1'b0);
      chk1("ar_exp_valid", ifc.exp_valid_out, 1'b0);
      chk1("ar_error", ifc.error_out, 1'b0);
      chk1("ar_tag", ifc.result_is_dec_out, 1'b0);
      chk("ar_base", ifc.exp_base_out, 64'h0);
      chk("ar_expo", ifc.exp_exponent_out, 64'h0);
      @(negedge clk);
      ifc.enc_valid_in = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
